baud_gen_multi: RTL and testbench
=================================

BAUD_GEN_MULTI -- requirements
Module: baud_gen_multi

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor registers and counter.
REQ-002 Parameter OSR, default 16, oversample ticks per baud bit; legal range 2..256.
REQ-003 Parameter DEFAULT_DIV, default 16'd162, divisor loaded at reset (50 MHz, 19200 baud, x16).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  count enable; low freezes all counters.
REQ-007 div_in  input  DIV_W  new divisor value.
REQ-008 div_ld  input  1  one-cycle strobe; captures div_in into pending register.
REQ-009 sync  input  1  one-cycle strobe; restarts bit phase (UART RX start-bit alignment).
REQ-010 os_tick  output  1  registered one-cycle oversample pulse.
REQ-011 baud_tick  output  1  registered one-cycle pulse, one per OSR os_ticks.
REQ-012 clk_out  output  1  registered square wave toggling on each baud_tick.
REQ-013 div_cur  output  DIV_W  divisor currently in force.

Function
REQ-014 Divider counter div_cnt SHALL count 0..div_cur on enabled cycles; oversample period = div_cur+1 enabled cycles.
REQ-015 os_tick SHALL be high for exactly the one cycle following the enabled cycle where div_cnt==div_cur; div_cnt wraps to 0 on that same edge.
REQ-016 div_cur==0 SHALL give os_tick high on every enabled cycle (period 1).
REQ-017 Oversample counter os_cnt (width clog2(OSR)) SHALL advance by 1 per os_tick event, wrapping OSR-1 -> 0.
REQ-018 baud_tick SHALL assert coincident with the os_tick whose event wraps os_cnt from OSR-1 to 0; never otherwise.
REQ-019 clk_out SHALL invert on the edge that asserts baud_tick; period = 2*OSR*(div_cur+1) cycles.
REQ-020 div_ld SHALL set a pending register and pending flag; div_ld with pending already set overwrites pending value (last load wins).
REQ-021 Pending value SHALL transfer to div_cur at the divider terminal-count edge (no truncated periods), or on the next edge if en=0, or on a sync edge; pending flag clears on transfer.
REQ-022 div_ld coincident with terminal count SHALL take effect for the immediately following period.
REQ-023 en=0 SHALL hold div_cnt, os_cnt, clk_out; os_tick and baud_tick SHALL be 0 while en=0.
REQ-024 sync SHALL clear div_cnt and os_cnt; os_tick/baud_tick 0 on the following cycle; clk_out unchanged; sync has priority over terminal count and acts regardless of en.
REQ-025 After sync with en=1, first os_tick SHALL occur div_cur+1 cycles later; first baud_tick OSR*(div_cur+1) cycles later.
REQ-026 All outputs SHALL be glitch-free register outputs; no combinational path input -> output.

Reset
REQ-027 rst_n low SHALL immediately force div_cnt=0, os_cnt=0, os_tick=0, baud_tick=0, clk_out=0, div_cur=DEFAULT_DIV, pending flag=0.
REQ-028 Reset mid-period SHALL discard any pending divisor; counting resumes from 0 on first enabled edge after rst_n rises.

Verification
REQ-029 OSR=4, load div 3, en=1 -> os_tick every 4 cycles, baud_tick every 16, clk_out period 32, duty 50%.
REQ-030 div 3 running, div_ld div_in=1 when div_cnt=1 -> current period completes at 4 cycles, then os_tick every 2 cycles; div_cur changes exactly at boundary.
REQ-031 en dropped for 10 cycles mid-period at div_cnt=2 -> no ticks during gap; next os_tick 2 enabled cycles after en returns.
REQ-032 sync at os_cnt=2, div_cnt=1 -> next os_tick 4 cycles later, baud_tick after 16, clk_out level unchanged by sync.
REQ-033 div_ld div_in=0 -> os_tick high every enabled cycle, baud_tick every OSR cycles.
REQ-034 rst_n pulsed low asynchronously mid-period with pending load -> outputs 0 immediately, div_cur=DEFAULT_DIV, pending value never applied.

Source files
------------

// File: rtl/baud_gen_multi.sv
// Programmable baud-rate generator: divider -> oversample tick -> baud tick -> square wave.
// Divisor changes are held pending and applied only on a period boundary, sync or idle.
module baud_gen_multi #(
  parameter int               DIV_W       = 16,
  parameter int               OSR         = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd162
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_ld,
  input  logic             sync,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             clk_out,
  output logic [DIV_W-1:0] div_cur
);

  localparam int               OS_W    = $clog2(OSR);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic             clk_out_q, clk_out_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;

  logic terminal;
  logic boundary;

  // >= rather than == so a divisor shrunk while idle can never strand the counter above it.
  assign terminal = en && (div_cnt_q >= div_cur_q);
  assign boundary = sync || terminal;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    os_cnt_d    = os_cnt_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    clk_out_d   = clk_out_q;

    if (sync) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (terminal) begin
      div_cnt_d = '0;
      os_tick_d = 1'b1;
      if (os_cnt_q == OS_LAST) begin
        os_cnt_d    = '0;
        baud_tick_d = 1'b1;
        clk_out_d   = ~clk_out_q;
      end else begin
        os_cnt_d = os_cnt_q + OS_ONE;
      end
    end else if (en) begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
  end

  // A load landing on a boundary edge bypasses the pending register so it rules the next period.
  always_comb begin
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;

    if (div_ld && boundary) begin
      div_cur_d = div_in;
      pend_d    = 1'b0;
    end else if (div_ld) begin
      pend_val_d = div_in;
      pend_d     = 1'b1;
    end else if (pend_q && (boundary || !en)) begin
      div_cur_d = pend_val_q;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      clk_out_q   <= 1'b0;
      div_cur_q   <= DEFAULT_DIV;
      pend_val_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      os_cnt_q    <= os_cnt_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      clk_out_q   <= clk_out_d;
      div_cur_q   <= div_cur_d;
      pend_val_q  <= pend_val_d;
      pend_q      <= pend_d;
    end
  end

  assign os_tick   = os_tick_q;
  assign baud_tick = baud_tick_q;
  assign clk_out   = clk_out_q;
  assign div_cur   = div_cur_q;

endmodule

// File: tb/tb_baud_gen_multi.sv
// Directed bench for baud_gen_multi (OSR=4, DEFAULT_DIV=5); tick edges are scheduled
// into queues as stimulus is applied and matched cycle-by-cycle against the outputs.
module tb_baud_gen_multi;

  localparam int DIV_W = 16;
  localparam int OSR   = 4;
  localparam logic [15:0] DEF_DIV = 16'd5;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div_in;
  logic        div_ld;
  logic        sync;
  logic        os_tick;
  logic        baud_tick;
  logic        clk_out;
  logic [15:0] div_cur;

  int n_vec;
  int n_err;
  int cyc;
  int exp_os[$];
  int exp_bd[$];

  baud_gen_multi #(
    .DIV_W      (DIV_W),
    .OSR        (OSR),
    .DEFAULT_DIV(DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .div_ld   (div_ld),
    .sync     (sync),
    .os_tick  (os_tick),
    .baud_tick(baud_tick),
    .clk_out  (clk_out),
    .div_cur  (div_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_seq(input int which, input int first, input int period, input int count);
    for (int k = 0; k < count; k++) begin
      if (which == 0) exp_os.push_back(first + k * period);
      else            exp_bd.push_back(first + k * period);
    end
  endtask

  // One rising edge, then sample on the falling edge and score both tick outputs.
  task automatic step();
    logic e_os;
    logic e_bd;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_os = 1'b0;
    e_bd = 1'b0;
    if (exp_os.size() > 0 && exp_os[0] == cyc) begin
      e_os = 1'b1;
      void'(exp_os.pop_front());
    end
    if (exp_bd.size() > 0 && exp_bd[0] == cyc) begin
      e_bd = 1'b1;
      void'(exp_bd.pop_front());
    end
    chk("os_tick", {31'd0, os_tick}, {31'd0, e_os});
    chk("baud_tick", {31'd0, baud_tick}, {31'd0, e_bd});
    $display("edge %0d: os_tick=%0b baud_tick=%0b clk_out=%0b div_cur=%0d",
             cyc, os_tick, baud_tick, clk_out, div_cur);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s, t0, t1, t2, t3, r;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    div_in = '0;
    div_ld = 1'b0;
    sync   = 1'b0;

    // reset state
    run(2);
    chk("rst_os_tick", {31'd0, os_tick}, 32'd0);
    chk("rst_baud_tick", {31'd0, baud_tick}, 32'd0);
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_div_cur", {16'd0, div_cur}, {16'd0, DEF_DIV});
    rst_n = 1'b1;

    // load divisor 3 while idle: pending first, applied on the following idle edge
    div_ld = 1'b1; div_in = 16'd3;
    step();
    div_ld = 1'b0;
    chk("idle_ld_pending", {16'd0, div_cur}, {16'd0, DEF_DIV});
    step();
    chk("idle_ld_applied", {16'd0, div_cur}, 32'd3);

    // sync + enable: os every 4, baud every 16, clk_out period 32
    s = cyc + 1;
    push_seq(0, s + 4, 4, 8);
    push_seq(1, s + 16, 16, 2);
    sync = 1'b1; en = 1'b1;
    step();
    sync = 1'b0;
    run(20);
    chk("clk_out_high_half", {31'd0, clk_out}, 32'd1);
    run(12);
    chk("clk_out_low_half", {31'd0, clk_out}, 32'd0);

    // div 3 -> 1 loaded mid-period at div_cnt=1: boundary at +4, then period 2
    t0 = cyc;
    push_seq(0, t0 + 4, 2, 5);
    push_seq(1, t0 + 10, 16, 1);
    step();
    div_ld = 1'b1; div_in = 16'd1;
    step();
    div_ld = 1'b0;
    step();
    chk("div_cur_before_bound", {16'd0, div_cur}, 32'd3);
    step();
    chk("div_cur_at_bound", {16'd0, div_cur}, 32'd1);
    run(8);
    chk("clk_out_after_div1", {31'd0, clk_out}, 32'd1);

    // div 0: os_tick every enabled cycle, baud every OSR cycles
    t1 = cyc;
    push_seq(0, t1 + 2, 1, 11);
    push_seq(1, t1 + 4, 4, 3);
    div_ld = 1'b1; div_in = 16'd0;
    step();
    div_ld = 1'b0;
    run(11);
    chk("div_cur_zero", {16'd0, div_cur}, 32'd0);
    chk("clk_out_div0", {31'd0, clk_out}, 32'd0);

    // load coincident with terminal count takes effect immediately; then an en gap at div_cnt=2
    t2 = cyc;
    push_seq(0, t2 + 1, 1, 1);
    push_seq(0, t2 + 15, 1, 1);
    div_ld = 1'b1; div_in = 16'd3;
    step();
    div_ld = 1'b0;
    chk("ld_at_terminal", {16'd0, div_cur}, 32'd3);
    run(2);
    en = 1'b0;
    run(10);
    chk("clk_out_hold_en0", {31'd0, clk_out}, 32'd0);
    en = 1'b1;
    run(3);

    // sync at os_cnt=2, div_cnt=1
    t3 = cyc + 1;
    push_seq(0, t3 + 4, 4, 4);
    push_seq(1, t3 + 16, 16, 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk_out_low", {31'd0, clk_out}, 32'd0);
    run(16);
    chk("clk_out_after_sync", {31'd0, clk_out}, 32'd1);

    // sync with en=0 still restarts the phase and leaves clk_out high
    step();
    sync = 1'b1; en = 1'b0;
    step();
    sync = 1'b0;
    chk("sync_en0_clk_out", {31'd0, clk_out}, 32'd1);
    en = 1'b1;
    push_seq(0, cyc + 4, 1, 1);
    run(4);

    // asynchronous reset mid-period with a pending load
    div_ld = 1'b1; div_in = 16'd7;
    step();
    div_ld = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_os_tick", {31'd0, os_tick}, 32'd0);
    chk("arst_baud_tick", {31'd0, baud_tick}, 32'd0);
    chk("arst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("arst_div_cur", {16'd0, div_cur}, {16'd0, DEF_DIV});
    run(2);
    rst_n = 1'b1;
    r = cyc + 1;
    push_seq(0, r + 5, 6, 2);
    run(12);
    chk("pending_discarded", {16'd0, div_cur}, {16'd0, DEF_DIV});

    chk("os_queue_drained", exp_os.size(), 32'd0);
    chk("baud_queue_drained", exp_bd.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
